// File: rtl/pe_pkg.sv
// pe_pkg: constants and types shared by the PE array and the row sequencers that drive it.
package pe_pkg;
    localparam int DATA_W = 8;
    localparam int PSUM_W = 10;
    localparam int TAPS   = 3;
    localparam int PE_LAT = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_FILT,
        S_LOAD_IFM,
        S_START,
        S_WAIT
    } seq_state_e;
endpackage

// File: rtl/pe_row_sequencer_out_reg.sv
// pe_out_reg: single-entry valid/ready holding register with a load port.
// A load always refills the slot, so a same-cycle drain and load keeps valid high.
module pe_out_reg #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         ready_i
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign valid_d = load_i | (valid_q & ~ready_i);
    assign data_d  = load_i ? load_data_i : data_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pe_row_sequencer.sv
// pe_row_sequencer: steps a 3-tap PE through one ifmap row (filter load, window slide,
// start, wait) and presents each partial sum on a valid/ready stream.
module pe_row_sequencer
    import pe_pkg::*;
#(
    parameter int IFMAP_W  = 8,
    parameter int WDOG_CYC = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cfg_start_i,
    input  logic              cfg_reuse_filt_i,
    input  logic [PSUM_W-1:0] cfg_bias_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic              filt_valid_i,
    input  logic [DATA_W-1:0] filt_data_i,
    output logic              filt_ready_o,
    input  logic              ifm_valid_i,
    input  logic [DATA_W-1:0] ifm_data_i,
    output logic              ifm_ready_o,
    output logic [DATA_W-1:0] pe_filter_o,
    output logic              pe_read_filter_o,
    output logic [DATA_W-1:0] pe_ifmap_o,
    output logic              pe_read_ifmap_o,
    output logic              pe_start_o,
    output logic [PSUM_W-1:0] pe_psum_o,
    input  logic [PSUM_W-1:0] pe_psum_i,
    input  logic              pe_psum_valid_i,
    output logic              out_valid_o,
    output logic [PSUM_W-1:0] out_data_o,
    input  logic              out_ready_i
);
    localparam int CNT_W = $clog2(IFMAP_W);
    localparam int WD_W  = $clog2(WDOG_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(IFMAP_W - 3);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(WDOG_CYC - 1);

    seq_state_e       state_q, state_d;
    logic [1:0]       need_q, need_d;
    logic [1:0]       filt_cnt_q, filt_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             err_q, err_d;
    logic             filt_hs, ifm_hs, capture, last_win, out_last;

    // Ifmap fetch stalls while a result is still held, so results are never overwritten.
    assign filt_ready_o     = state_q == S_LOAD_FILT;
    assign ifm_ready_o      = state_q == S_LOAD_IFM && !out_valid_o;
    assign pe_start_o       = state_q == S_START;
    assign busy_o           = state_q != S_IDLE;
    assign err_o            = err_q;
    assign filt_hs          = filt_valid_i & filt_ready_o;
    assign ifm_hs           = ifm_valid_i & ifm_ready_o;
    assign pe_read_filter_o = filt_hs;
    assign pe_read_ifmap_o  = ifm_hs;
    assign pe_filter_o      = filt_hs ? filt_data_i : '0;
    assign pe_ifmap_o       = ifm_hs ? ifm_data_i : '0;
    assign pe_psum_o        = cfg_bias_i;
    assign capture          = state_q == S_WAIT && pe_psum_valid_i;
    assign last_win         = out_cnt_q == LAST_M1;
    assign done_o           = out_valid_o & out_ready_i & out_last;

    always_comb begin
        state_d    = state_q;
        need_d     = need_q;
        filt_cnt_d = filt_cnt_q;
        out_cnt_d  = out_cnt_q;
        wdog_d     = '0;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: if (cfg_start_i) begin
                state_d    = cfg_reuse_filt_i ? S_LOAD_IFM : S_LOAD_FILT;
                need_d     = 2'(TAPS);
                filt_cnt_d = '0;
                out_cnt_d  = '0;
                err_d      = 1'b0;
            end
            S_LOAD_FILT: if (filt_hs) begin
                filt_cnt_d = filt_cnt_q + 2'd1;
                state_d    = filt_cnt_q == 2'(TAPS - 1) ? S_LOAD_IFM : S_LOAD_FILT;
            end
            S_LOAD_IFM: if (ifm_hs) begin
                need_d  = need_q - 2'd1;
                state_d = need_q == 2'd1 ? S_START : S_LOAD_IFM;
            end
            S_START: begin
                wdog_d  = wdog_q + 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (pe_psum_valid_i) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    need_d    = 2'd1;
                    state_d   = last_win ? S_IDLE : S_LOAD_IFM;
                end else if (wdog_q >= WD_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            need_q     <= '0;
            filt_cnt_q <= '0;
            out_cnt_q  <= '0;
            wdog_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            need_q     <= need_d;
            filt_cnt_q <= filt_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
        end
    end

    // The slot carries a last-of-row flag so done_o can fire on that result's handshake.
    pe_out_reg #(.W(PSUM_W + 1)) u_out_reg (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .load_i      (capture),
        .load_data_i ({last_win, pe_psum_i}),
        .valid_o     (out_valid_o),
        .data_o      ({out_last, out_data_o}),
        .ready_i     (out_ready_i)
    );
endmodule

// File: tb/tb_pe_row_sequencer.sv
// tb_pe_row_sequencer: table of rows (hand-computed and randomized) driven through the
// sequencer with a behavioural PE; results compared against a direct convolution of each row.
module tb_pe_row_sequencer;
    localparam int IFMAP_W = 8;
    localparam int NOUT    = IFMAP_W - 2;
    localparam int NROWS   = 16;
    localparam int M_READY = 0, M_RAND = 1, M_BP = 2, M_WDOG = 3, M_RST = 4;

    logic       clk_i = 0, rstn_i = 1;
    logic       cfg_start_i = 0, cfg_reuse_filt_i = 0;
    logic [9:0] cfg_bias_i = 0;
    logic       busy_o, done_o, err_o;
    logic       filt_valid_i = 0, filt_ready_o;
    logic [7:0] filt_data_i = 0;
    logic       ifm_valid_i = 0, ifm_ready_o;
    logic [7:0] ifm_data_i = 0;
    logic [7:0] pe_filter_o, pe_ifmap_o;
    logic       pe_read_filter_o, pe_read_ifmap_o, pe_start_o;
    logic [9:0] pe_psum_o, pe_psum_i = 0;
    logic       pe_psum_valid_i = 0;
    logic       out_valid_o, out_ready_i = 0;
    logic [9:0] out_data_o;

    always #5 clk_i = ~clk_i;

    pe_row_sequencer #(.IFMAP_W(IFMAP_W), .WDOG_CYC(8)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cfg_start_i(cfg_start_i), .cfg_reuse_filt_i(cfg_reuse_filt_i), .cfg_bias_i(cfg_bias_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .filt_valid_i(filt_valid_i), .filt_data_i(filt_data_i), .filt_ready_o(filt_ready_o),
        .ifm_valid_i(ifm_valid_i), .ifm_data_i(ifm_data_i), .ifm_ready_o(ifm_ready_o),
        .pe_filter_o(pe_filter_o), .pe_read_filter_o(pe_read_filter_o),
        .pe_ifmap_o(pe_ifmap_o), .pe_read_ifmap_o(pe_read_ifmap_o),
        .pe_start_o(pe_start_o), .pe_psum_o(pe_psum_o),
        .pe_psum_i(pe_psum_i), .pe_psum_valid_i(pe_psum_valid_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i)
    );

    typedef struct packed {
        logic [2:0][7:0]         f;
        logic [IFMAP_W-1:0][7:0] x;
        logic [9:0]              bias;
        logic                    reuse;
        logic [2:0]              mode;
        logic [NOUT-1:0][9:0]    want;
    } vec_t;

    vec_t       tab[NROWS];
    int         errors = 0, checks = 0;
    logic [7:0] pe_w[3], pe_x[3];
    logic [9:0] pe_res;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [9:0] ref_out(input vec_t v, input int k);
        int s = 0;
        for (int i = 0; i < 3; i++) s += int'(v.f[i]) * int'(v.x[k + i]);
        return v.bias + 10'(s >>> 6);
    endfunction

    task automatic idle_inputs();
        cfg_start_i = 0;
        filt_valid_i = 0;
        ifm_valid_i = 0;
        pe_psum_valid_i = 0;
        out_ready_i = 0;
    endtask

    task automatic run_row(input int r, input vec_t v);
        int fi = 0, xi = 0, nout = 0, nstart = 0, cyc_start = -100, pe_due = -1;
        int bp_left = 0, bp_bad = 0, proto = 0, s;
        bit bp_done = 0, inflight = 0, prev_start = 0, finished = 0, seen_busy = 0, full;
        full = v.mode == M_READY || v.mode == M_BP || v.mode == M_RST;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            @(negedge clk_i);
            cfg_start_i = (cyc == 0) || (busy_o && $urandom_range(0, 3) == 0);
            cfg_reuse_filt_i = (cyc == 0) ? v.reuse : 1'($urandom);
            cfg_bias_i = v.bias;
            filt_valid_i = fi < 3 && (full || $urandom_range(0, 3) != 0);
            filt_data_i = filt_valid_i ? v.f[fi] : 8'($urandom);
            ifm_valid_i = xi < IFMAP_W && (full || $urandom_range(0, 3) != 0);
            ifm_data_i = ifm_valid_i ? v.x[xi] : 8'($urandom);
            if (v.mode == M_BP && !bp_done && out_valid_o) begin
                bp_done = 1;
                bp_left = 20;
            end
            out_ready_i = (v.mode == M_RAND) ? ($urandom_range(0, 2) != 0) : (bp_left == 0);
            pe_psum_valid_i = (cyc == pe_due) || (!inflight && $urandom_range(0, 7) == 0);
            pe_psum_i = (cyc == pe_due) ? pe_res : 10'($urandom);
            #1;
            if (busy_o && !seen_busy) begin
                seen_busy = 1;
                check($sformatf("row%0d err_clear", r), err_o, 0);
            end
            if (pe_psum_o !== cfg_bias_i) proto++;
            if (filt_valid_i && filt_ready_o) begin
                if (!pe_read_filter_o || pe_filter_o !== filt_data_i || inflight) proto++;
                pe_w[0] = pe_w[1]; pe_w[1] = pe_w[2]; pe_w[2] = filt_data_i;
                fi++;
            end else if (pe_read_filter_o) proto++;
            if (v.reuse && filt_ready_o) proto++;
            if (ifm_valid_i && ifm_ready_o) begin
                if (!pe_read_ifmap_o || pe_ifmap_o !== ifm_data_i || inflight || out_valid_o) proto++;
                pe_x[0] = pe_x[1]; pe_x[1] = pe_x[2]; pe_x[2] = ifm_data_i;
                xi++;
            end else if (pe_read_ifmap_o) proto++;
            if (bp_left > 0) begin
                if (!out_valid_o || out_data_o !== v.want[0] || ifm_ready_o || pe_read_ifmap_o) bp_bad++;
                bp_left--;
            end
            if (pe_start_o) begin
                if (prev_start) proto++;
                nstart++;
                inflight = 1;
                cyc_start = cyc;
                s = 0;
                for (int i = 0; i < 3; i++) s += int'(pe_w[i]) * int'(pe_x[i]);
                pe_res = cfg_bias_i + 10'(s >>> 6);
                if (v.mode != M_WDOG) pe_due = cyc + 5;
            end
            prev_start = pe_start_o;
            if (cyc == pe_due) inflight = 0;
            if (out_valid_o && out_ready_i) begin
                if (nout < NOUT)
                    check($sformatf("row%0d out%0d", r, nout), {done_o, out_data_o},
                          {nout == NOUT - 1, v.want[nout]});
                else proto++;
                nout++;
            end else if (done_o) proto++;
            if (done_o) begin
                finished = 1;
                check($sformatf("row%0d idle_at_done", r), busy_o, 0);
            end
            if (v.mode == M_WDOG && err_o) begin
                finished = 1;
                check("wdog_latency", cyc - cyc_start, 8);
                check("wdog_idle_no_out", {busy_o, out_valid_o}, 0);
            end
            if (v.mode == M_RST && nstart == 3 && cyc == cyc_start + 2) begin
                rstn_i = 0;
                #1;
                check("async_reset", {busy_o, done_o, err_o, filt_ready_o, ifm_ready_o,
                      pe_read_filter_o, pe_read_ifmap_o, pe_start_o, out_valid_o, out_data_o,
                      pe_filter_o, pe_ifmap_o, pe_psum_o}, {35'd0, cfg_bias_i});
                finished = 1;
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL row%0d timeout: got no completion, expected done/err within 600 cycles", r);
        end
        check($sformatf("row%0d protocol", r), proto, 0);
        if (v.mode == M_BP) check("bp_hold", {bp_done, 32'(bp_bad)}, {1'b1, 32'd0});
        if (v.mode != M_WDOG && v.mode != M_RST) check($sformatf("row%0d count", r), nout, NOUT);
    endtask

    initial begin
        logic [2:0][7:0] last_f;
        for (int k = 0; k < 7; k++) begin
            tab[k] = '0;
            for (int i = 0; i < 3; i++) tab[k].f[i] = 8'd64;
            for (int i = 0; i < IFMAP_W; i++) tab[k].x[i] = 8'(i + 1);
        end
        tab[1].reuse = 1; tab[1].bias = 10'd5;
        tab[2].reuse = 1; tab[2].mode = M_BP;
        tab[3].mode = M_WDOG;
        tab[4].reuse = 1; tab[4].mode = M_RAND;
        tab[5].mode = M_RST;
        for (int k = 0; k < 7; k++)
            for (int n = 0; n < NOUT; n++) tab[k].want[n] = tab[k].bias + 10'(6 + 3 * n);
        last_f = tab[6].f;
        for (int k = 7; k < NROWS; k++) begin
            tab[k] = '0;
            tab[k].reuse = 1'($urandom);
            tab[k].mode = M_RAND;
            tab[k].bias = 10'($urandom);
            for (int i = 0; i < 3; i++) tab[k].f[i] = tab[k].reuse ? last_f[i] : 8'($urandom);
            last_f = tab[k].f;
            for (int i = 0; i < IFMAP_W; i++) tab[k].x[i] = 8'($urandom);
            for (int n = 0; n < NOUT; n++) tab[k].want[n] = ref_out(tab[k], n);
        end

        cfg_bias_i = 10'h2a5;
        filt_data_i = 8'hff;
        ifm_data_i = 8'h81;
        #2 rstn_i = 0;
        #1;
        check("reset_out", {busy_o, done_o, err_o, filt_ready_o, ifm_ready_o, pe_read_filter_o,
              pe_read_ifmap_o, pe_start_o, out_valid_o, out_data_o, pe_filter_o, pe_ifmap_o,
              pe_psum_o}, {35'd0, 10'h2a5});
        repeat (3) @(negedge clk_i);
        rstn_i = 1;

        for (int r = 0; r < NROWS; r++) begin
            run_row(r, tab[r]);
            @(negedge clk_i);
            idle_inputs();
            if (tab[r].mode == M_RST) begin
                repeat (2) @(negedge clk_i);
                rstn_i = 1;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
